aes_decrypt_key_expand: RTL and testbench
=========================================

AES_DECRYPT_KEY_EXPAND -- requirements
Module: aes_decrypt_key_expand

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, meaning the AES-128 round count; only the value 10 is supported.
REQ-002 Port clk SHALL be input, 1 bit: rising-edge clock.
REQ-003 Port reset_n SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-004 Port cipher_key SHALL be input, 128 bits: the AES-128 cipher key; bits [127:96] are word w0.
REQ-005 Port key_load SHALL be input, 1 bit: sample cipher_key and start the forward expansion.
REQ-006 Port key_rewind SHALL be input, 1 bit: restore the stored final round key K10 without re-expanding.
REQ-007 Port round_key_en SHALL be input, 1 bit: step to the previous round key.
REQ-008 Port round_key_out SHALL be output, 128 bits: the current round key Kr (registered).
REQ-009 Port round_num_out SHALL be output, 4 bits: the index r of round_key_out.
REQ-010 Port key_ready SHALL be output, 1 bit: high when round_key_out is valid for decryption.
REQ-011 Port busy SHALL be output, 1 bit: high during the forward expansion.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXPAND and READY.
REQ-013 On any clock edge with key_load=1, in any state, the block SHALL load key_reg <= cipher_key and cnt <= 0, then go to EXPAND; key_load has top priority.
REQ-014 In EXPAND, each cycle SHALL apply one forward step and increment cnt:
  - Temp = SubWord(RotWord(w3)) ^ Rcon(cnt+1).
  - w0' = w0 ^ Temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
REQ-015 Rcon(i) for i=1..10 SHALL be top-byte 01,02,04,08,10,20,40,80,1b,36, with the low three bytes zero.
REQ-016 On the edge where cnt becomes 10, the block SHALL copy K10 into last_key_reg and go to READY.
  - key_ready SHALL rise 10 edges after the key_load edge.
  - busy SHALL be high exactly during those 10 cycles.
REQ-017 In READY with round_key_en=1 and cnt>0, the block SHALL apply one inverse step and decrement cnt in one cycle:
  - b3 = a3^a2; b2 = a2^a1; b1 = a1^a0.
  - b0 = a0 ^ SubWord(RotWord(b3)) ^ Rcon(cnt).
REQ-018 In READY with cnt=0, round_key_en SHALL be ignored; K0 is held and there is no wrap-around.
REQ-019 In READY with key_rewind=1, the block SHALL load key_reg <= last_key_reg and cnt <= 10 in one cycle.
  - key_rewind SHALL have priority over round_key_en.
  - key_ready SHALL stay high.
REQ-020 key_rewind and round_key_en SHALL be ignored in IDLE and EXPAND.
REQ-021 key_load asserted during EXPAND SHALL restart the expansion from the new key.
  - key_ready SHALL stay low.
  - last_key_reg SHALL NOT be updated by the aborted run.
REQ-022 In IDLE and EXPAND, key_ready SHALL be 0; in READY it SHALL be 1.
REQ-023 round_key_out SHALL equal key_reg, and round_num_out SHALL equal cnt.
REQ-024 S-box logic SHALL be shared: a single 4-byte SubWord instance, muxed between the forward (w3) and inverse (b3) operand.
REQ-025 The block SHALL have no combinational path from any input to any output.

Reset
REQ-026 While reset_n=0, the block SHALL asynchronously clear state to IDLE and set key_reg, last_key_reg and cnt to 0.
  - All outputs SHALL be 0.
  - Reset SHALL abort any expansion in progress.
REQ-027 After reset release, the block SHALL remain in IDLE until key_load.

Verification
REQ-028 The bench SHALL apply key_load with cipher_key=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: busy high for 10 cycles, then key_ready=1.
  - round_num_out=10 and round_key_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 From the REQ-028 state, the bench SHALL pulse round_key_en once.
  - Required: round_num_out=9 and round_key_out=ac7766f319fadc2128d12941575c006e.
REQ-030 From REQ-028, the bench SHALL hold round_key_en for 12 cycles.
  - Required: round_num_out steps 10..0, then holds 0.
  - round_key_out ends and stays at 2b7e151628aed2a6abf7158809cf4f3c.
REQ-031 The bench SHALL apply key_rewind with round_key_en simultaneously at cnt=3.
  - Required: next cycle round_num_out=10 and round_key_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 The bench SHALL apply key_load with 000102030405060708090a0b0c0d0e0f, then re-assert key_load at EXPAND cycle 5 with the same key.
  - Required: key_ready asserts 10 cycles after the second load.
  - round_key_out=13111d7fe3944a17f307a78b4d2b30c5.
REQ-033 The bench SHALL assert reset_n=0 mid-EXPAND and mid-READY.
  - Required: outputs are 0 immediately, without a clock edge.
  - key_rewind after release has no effect until a new key_load completes.

Source files
------------

// File: rtl/aes_decrypt_key_expand.sv
// AES-128 decryption key schedule.
// A key load runs the forward expansion once (one round per cycle) and stores K10.
// Decryption then walks the keys backwards one round per enable, recomputing each
// previous key from the current one. A rewind restores K10 without re-expanding.
// One SubWord instance is shared by the forward and inverse steps.
// Only NUM_ROUNDS = 10 (AES-128) is supported.

module aes_decrypt_key_expand #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] cipher_key,
    input  logic         key_load,
    input  logic         key_rewind,
    input  logic         round_key_en,
    output logic [127:0] round_key_out,
    output logic [3:0]   round_num_out,
    output logic         key_ready,
    output logic         busy
);

    // Byte 0x00 sits in the most significant byte; lookups index from the top.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    state_e       state;
    logic [127:0] key_reg;
    logic [127:0] last_key_reg;
    logic [3:0]   cnt;

    logic [31:0]  a0, a1, a2, a3;
    logic [31:0]  b0, b1, b2, b3;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [3:0]   rcon_idx;
    logic [31:0]  rcon_word;
    logic [127:0] fwd_key;
    logic [127:0] inv_key;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // 255 - b == ~b for an 8-bit index.
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        unique case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Shared SubWord(RotWord(x)) plus both candidate next keys.
    always_comb begin
        {a0, a1, a2, a3} = key_reg;
        b3 = a3 ^ a2;
        b2 = a2 ^ a1;
        b1 = a1 ^ a0;
        // Forward step uses w3, inverse step uses the recovered b3.
        sub_in    = (state == StExpand) ? {a3[23:0], a3[31:24]} : {b3[23:0], b3[31:24]};
        sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                     sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        rcon_idx  = (state == StExpand) ? cnt + 4'd1 : cnt;
        rcon_word = {rcon(rcon_idx), 24'h000000};
        f0 = a0 ^ sub_out ^ rcon_word;
        f1 = a1 ^ f0;
        f2 = a2 ^ f1;
        f3 = a3 ^ f2;
        b0 = a0 ^ sub_out ^ rcon_word;
        fwd_key = {f0, f1, f2, f3};
        inv_key = {b0, b1, b2, b3};
    end

    // Control FSM with key/count registers and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            key_reg      <= '0;
            last_key_reg <= '0;
            cnt          <= '0;
            key_ready    <= 1'b0;
            busy         <= 1'b0;
        end else if (key_load) begin
            key_reg   <= cipher_key;
            cnt       <= '0;
            state     <= StExpand;
            busy      <= 1'b1;
            key_ready <= 1'b0;
        end else begin
            unique case (state)
                StIdle: ;
                StExpand: begin
                    key_reg <= fwd_key;
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'(NUM_ROUNDS - 1)) begin
                        last_key_reg <= fwd_key;
                        state        <= StReady;
                        busy         <= 1'b0;
                        key_ready    <= 1'b1;
                    end
                end
                StReady: begin
                    if (key_rewind) begin
                        key_reg <= last_key_reg;
                        cnt     <= 4'(NUM_ROUNDS);
                    end else if (round_key_en && cnt != 4'd0) begin
                        key_reg <= inv_key;
                        cnt     <= cnt - 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign round_key_out = key_reg;
    assign round_num_out = cnt;

endmodule

// File: tb/tb_aes_decrypt_key_expand.sv
// Bench for aes_decrypt_key_expand: known-answer vectors plus random traffic checked
// against a reference that expands the whole key schedule up front and simply
// indexes it by round number. The S-box is derived from GF(2^8) inversion.

module tb_aes_decrypt_key_expand;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] cipher_key = '0;
    logic         key_load = 1'b0;
    logic         key_rewind = 1'b0;
    logic         round_key_en = 1'b0;
    logic [127:0] round_key_out;
    logic [3:0]   round_num_out;
    logic         key_ready;
    logic         busy;

    aes_decrypt_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cipher_key    (cipher_key),
        .key_load      (key_load),
        .key_rewind    (key_rewind),
        .round_key_en  (round_key_en),
        .round_key_out (round_key_out),
        .round_num_out (round_num_out),
        .key_ready     (key_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] A_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A_K9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] B_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] rk_tab [11];
    int           m_mode = 0;   // 0 idle, 1 expanding, 2 ready
    int           m_cnt  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_m[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    // Full forward schedule w[0..43], grouped into round keys K0..K10.
    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        {w[0], w[1], w[2], w[3]} = key;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]};
                t = t ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_step(input logic ld, input logic [127:0] key, input logic rw,
                              input logic en);
        if (ld) begin
            expand_key(key);
            m_cnt  = 0;
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_cnt++;
            if (m_cnt == 10) m_mode = 2;
        end else if (m_mode == 2) begin
            if (rw) m_cnt = 10;
            else if (en && m_cnt > 0) m_cnt--;
        end
    endtask

    task automatic check_model(input string where);
        logic [127:0] exp_key = (m_mode == 0) ? 128'h0 : rk_tab[m_cnt];
        chk({where, ".key"}, round_key_out, exp_key);
        chk({where, ".num"}, 128'(round_num_out), 128'(m_cnt));
        chk({where, ".ready"}, 128'(key_ready), 128'(m_mode == 2));
        chk({where, ".busy"}, 128'(busy), 128'(m_mode == 1));
    endtask

    task automatic cycle(input string where, input logic ld, input logic [127:0] key,
                         input logic rw, input logic en);
        cipher_key   = key;
        key_load     = ld;
        key_rewind   = rw;
        round_key_en = en;
        @(posedge clk);
        model_step(ld, key, rw, en);
        #1;
        check_model(where);
        key_load     = 1'b0;
        key_rewind   = 1'b0;
        round_key_en = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear with no edge.
    task automatic pulse_reset(input string where);
        reset_n = 1'b0;
        #2;
        m_mode = 0;
        m_cnt  = 0;
        check_model(where);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [127:0] rkey;
        build_sbox();
        #2;
        m_mode = 0;
        m_cnt  = 0;
        check_model("por");
        #1;
        reset_n = 1'b1;

        // Idle ignores rewind/enable.
        cycle("idle_rw", 1'b0, KEY_A, 1'b1, 1'b1);
        cycle("idle", 1'b0, KEY_A, 1'b0, 1'b0);

        // Expansion of the FIPS-197 key.
        cycle("load_a", 1'b1, KEY_A, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("exp_a", 1'b0, KEY_A, 1'b1, 1'b1);
        chk("kat_a_k10", round_key_out, A_K10);
        chk("kat_a_num10", 128'(round_num_out), 128'd10);
        cycle("step9", 1'b0, KEY_A, 1'b0, 1'b1);
        chk("kat_a_k9", round_key_out, A_K9);
        chk("kat_a_num9", 128'(round_num_out), 128'd9);

        // Rewind then walk down to K0 and hold there.
        cycle("rewind", 1'b0, KEY_A, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle("walk", 1'b0, KEY_A, 1'b0, 1'b1);
        chk("kat_a_k0", round_key_out, KEY_A);
        chk("kat_a_num0", 128'(round_num_out), 128'd0);

        // Rewind has priority over enable.
        cycle("rewind2", 1'b0, KEY_A, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle("walk3", 1'b0, KEY_A, 1'b0, 1'b1);
        chk("kat_a_num3", 128'(round_num_out), 128'd3);
        cycle("rw_en", 1'b0, KEY_A, 1'b1, 1'b1);
        chk("kat_rw_k10", round_key_out, A_K10);
        chk("kat_rw_num", 128'(round_num_out), 128'd10);

        // Restart mid-expansion.
        cycle("load_b", 1'b1, KEY_B, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("exp_b", 1'b0, KEY_B, 1'b0, 1'b0);
        cycle("reload_b", 1'b1, KEY_B, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("exp_b2", 1'b0, KEY_B, 1'b0, 1'b0);
        chk("kat_b_k10", round_key_out, B_K10);
        chk("kat_b_ready", 128'(key_ready), 128'd1);

        // Reset mid-expansion, then rewind must do nothing.
        cycle("load_a2", 1'b1, KEY_A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("exp_a2", 1'b0, KEY_A, 1'b0, 1'b0);
        pulse_reset("rst_exp");
        cycle("rst_rw", 1'b0, KEY_A, 1'b1, 1'b1);

        // Reset mid-ready, then rewind must do nothing.
        cycle("load_a3", 1'b1, KEY_A, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("exp_a3", 1'b0, KEY_A, 1'b0, 1'b0);
        cycle("step_a3", 1'b0, KEY_A, 1'b0, 1'b1);
        pulse_reset("rst_rdy");
        cycle("rst_rw2", 1'b0, KEY_A, 1'b1, 1'b0);
        cycle("rst_idle", 1'b0, KEY_A, 1'b0, 1'b1);

        // Random traffic.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        cycle("rnd_load", 1'b1, rkey, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            cycle("rnd", $urandom_range(0, 24) == 0, rkey, $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
